// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one single-ported RAM between instruction fetch and
// load/store; data has priority, fetch wins a conflict after MAX_WAIT losses.
module mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic              grant_dm
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t            state_r, state_s;
  logic [3:0]        wait_cnt_r, wait_cnt_s;
  logic [ADDR_W-1:0] mem_address_r, mem_address_s;
  logic [DATA_W-1:0] mem_data_in_r, mem_data_in_s;
  logic              we_r, we_s;
  logic              re_r, re_s;
  logic              write_op_r, write_op_s;
  logic [DATA_W-1:0] if_rdata_r, if_rdata_s;
  logic [DATA_W-1:0] dm_rdata_r, dm_rdata_s;
  logic              if_ack_r, if_ack_s;
  logic              dm_ack_r, dm_ack_s;
  logic              grant_dm_r, grant_dm_s;
  logic              busy_r, busy_s;

  // Next-state and next-output logic for the access sequencer
  always_comb begin
    state_s       = state_r;
    wait_cnt_s    = wait_cnt_r;
    mem_address_s = mem_address_r;
    mem_data_in_s = mem_data_in_r;
    write_op_s    = write_op_r;
    if_rdata_s    = if_rdata_r;
    dm_rdata_s    = dm_rdata_r;
    grant_dm_s    = grant_dm_r;
    we_s          = 1'b0;
    re_s          = 1'b0;
    if_ack_s      = 1'b0;
    dm_ack_s      = 1'b0;

    case (state_r)
      IDLE: begin
        if (dm_req && (!if_req || (wait_cnt_r != MAX_WAIT_C))) begin
          mem_address_s = dm_addr;
          grant_dm_s    = 1'b1;
          write_op_s    = dm_we;
          state_s       = ISSUE;
          if (dm_we) begin
            mem_data_in_s = dm_wdata;
            we_s          = 1'b1;
          end else begin
            re_s          = 1'b1;
          end
          // Fetch only accrues credit when it actually lost a conflict
          if (if_req && (wait_cnt_r < MAX_WAIT_C)) begin
            wait_cnt_s = wait_cnt_r + 4'd1;
          end else begin
            wait_cnt_s = wait_cnt_r;
          end
        end else if (if_req) begin
          mem_address_s = if_addr;
          grant_dm_s    = 1'b0;
          write_op_s    = 1'b0;
          re_s          = 1'b1;
          wait_cnt_s    = 4'd0;
          state_s       = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (write_op_r) begin
          dm_ack_s = 1'b1;
          state_s  = ACK;
        end else begin
          state_s  = CAPTURE;
        end
      end
      CAPTURE: begin
        // RAM output is valid one cycle after the read strobe was sampled
        if (grant_dm_r) begin
          dm_rdata_s = mem_data_out;
          dm_ack_s   = 1'b1;
        end else begin
          if_rdata_s = mem_data_out;
          if_ack_s   = 1'b1;
        end
        state_s = ACK;
      end
      ACK: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State and registered-output update with synchronous clear
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r       <= IDLE;
      wait_cnt_r    <= 4'd0;
      mem_address_r <= '0;
      mem_data_in_r <= '0;
      we_r          <= 1'b0;
      re_r          <= 1'b0;
      write_op_r    <= 1'b0;
      if_rdata_r    <= '0;
      dm_rdata_r    <= '0;
      if_ack_r      <= 1'b0;
      dm_ack_r      <= 1'b0;
      grant_dm_r    <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      wait_cnt_r    <= wait_cnt_s;
      mem_address_r <= mem_address_s;
      mem_data_in_r <= mem_data_in_s;
      we_r          <= we_s;
      re_r          <= re_s;
      write_op_r    <= write_op_s;
      if_rdata_r    <= if_rdata_s;
      dm_rdata_r    <= dm_rdata_s;
      if_ack_r      <= if_ack_s;
      dm_ack_r      <= dm_ack_s;
      grant_dm_r    <= grant_dm_s;
      busy_r        <= busy_s;
    end
  end

  assign mem_address      = mem_address_r;
  assign mem_data_in      = mem_data_in_r;
  assign mem_write_enable = we_r;
  assign mem_read_enable  = re_r;
  assign if_rdata         = if_rdata_r;
  assign dm_rdata         = dm_rdata_r;
  assign if_ack           = if_ack_r;
  assign dm_ack           = dm_ack_r;
  assign grant_dm         = grant_dm_r;
  assign busy             = busy_r;

endmodule
